cdc_stable_capture: RTL and testbench
=====================================

Name: cdc_stable_capture

Overview:
Destination-domain qualifier that sits directly downstream of the gray-code CDC synchronizer and consumes its dst_data/dst_valid. A multi-bit value that has crossed a clock domain is only trusted once it has been stable for a programmable number of consecutive valid samples. Each qualified new value is committed as one event into a small output FIFO with valid/ready handshake. Decoded glitches, meaning transient values that revert, are filtered out and counted.

Parameters:
WIDTH, 8, data width; must match the synchronizer WIDTH.
STABLE_CYCLES, 2, consecutive identical valid samples required to commit; must be >=1.
FIFO_DEPTH, 4, output event FIFO entries; must be a power of 2 and >=2.
CNT_W, 8, width of the saturating glitch and drop counters.

Ports:
clk  input  1  destination-domain clock.
reset_n  input  1  asynchronous active-low reset.
in_data  input  WIDTH  decoded synchronized value from the synchronizer dst_data.
in_valid  input  1  synchronizer dst_valid; the block samples only when this is high.
out_data  output  WIDTH  FIFO head value.
out_valid  output  1  FIFO not empty.
out_ready  input  1  consumer accepts the head.
fifo_count  output  $clog2(FIFO_DEPTH)+1  number of occupied entries.
busy  output  1  state is SETTLE.
overflow  output  1  one-cycle pulse when a commit is dropped because the FIFO is full.
glitch_cnt  output  CNT_W  saturating count of rejected transients.
drop_cnt  output  CNT_W  saturating count of dropped commits.

Behaviour:
- Reset (asynchronous, active-low):
  - state=IDLE, last_val=0, candidate=0, cnt=0.
  - FIFO empty, so out_valid=0, fifo_count=0, out_data=0.
  - overflow=0, glitch_cnt=0, drop_cnt=0, busy=0.
  - last_val=0 matches the synchronizer reset value, so no spurious event is produced after reset.
  - Reset asserted mid-settle or with a non-empty FIFO discards all in-flight state.
- Sampling: a "sample" is any rising clk edge with in_valid=1. Edges with in_valid=0 are ignored, and candidate and cnt hold.
- IDLE state:
  - Sample with in_data==last_val: no action.
  - Sample with in_data!=last_val:
    - If STABLE_CYCLES==1, commit immediately.
    - Otherwise set candidate=in_data, cnt=1, and go to SETTLE.
- SETTLE state:
  - Sample with in_data==candidate: cnt+1. When cnt reaches STABLE_CYCLES, commit and go to IDLE.
  - Sample with in_data==last_val: this is a glitch. glitch_cnt+1 (saturating), go to IDLE, no commit.
  - Sample with any other value: set candidate=in_data, cnt=1, stay in SETTLE. No glitch is counted.
- Commit: last_val<=candidate (or in_data for STABLE_CYCLES==1), then push to the FIFO.
- Latency: out_valid rises in the cycle after the STABLE_CYCLES-th consecutive matching sample edge, provided the FIFO was empty.
- FIFO:
  - Push on commit; pop when out_valid && out_ready.
  - out_data is the head entry, driven from registered storage.
  - Order is strictly FIFO.
  - Pointers wrap modulo FIFO_DEPTH.
- Full boundary:
  - Commit while full with no pop in the same cycle: the new value is dropped, overflow pulses for 1 cycle, and drop_cnt+1 (saturating). last_val still updates, so a dropped value is not re-reported.
  - Commit while full with a pop in the same cycle: both happen, no drop, and count is unchanged.
- Empty boundary: out_ready while empty has no effect. A push into an empty FIFO makes out_valid=1 in the next cycle; there is no combinational bypass.
- Counters saturate at 2^CNT_W-1 and never wrap.
- Parameter violations (STABLE_CYCLES<1, or FIFO_DEPTH not a power of 2) are flagged by elaboration-time assertion.

Decomposition:
- Shared package cdc_pkg holds:
  - typedef enum logic {CAP_IDLE, CAP_SETTLE} cap_state_e;
  - the CNT_W default constant;
  - a saturating-increment function reused by both counters.
- One sub-module, cdc_event_fifo: single-clock FIFO parameterized by WIDTH and FIFO_DEPTH, with asynchronous active-low reset, and push/pop/full/empty/count ports.
- cdc_stable_capture contains the FSM, comparators and counters, and instantiates cdc_event_fifo.

Test Plan:
1. Reset, then hold in_data=0x00 with in_valid=1 for 20 cycles -> out_valid stays 0, glitch_cnt=0.
2. STABLE_CYCLES=2: in_data goes 0x00->0x5A and holds -> out_valid=1 in the cycle after the 2nd 0x5A sample, out_data=0x5A, fifo_count=1. Pop -> out_valid=0.
3. Glitch: in_data sequence 0x5A, 0x7F (1 sample), then 0x5A -> no event, glitch_cnt=1, busy high for 1 cycle. Repeat with in_valid=0 gaps inserted -> same result; the gaps do not reset cnt.
4. Overflow with FIFO_DEPTH=4 and out_ready=0: commit 0x01, 0x02, 0x03, 0x04, 0x05 -> fifo_count=4, overflow pulses once, drop_cnt=1. Draining yields 0x01..0x04 in order.
5. Full with simultaneous pop: FIFO full with out_ready=1 on the commit cycle of 0x06 -> no overflow, fifo_count stays 4, and the tail entry is 0x06.
6. Assert reset_n low mid-SETTLE with fifo_count=2 -> all outputs return to their reset values at once. After release, in_data equal to the previous last_val is reported as a new event, because last_val is 0 again.

Source files
------------

// File: rtl/cdc_stable_capture_pkg.sv
// Shared definitions for the stable-capture qualifier slice.
//   cap_state_e   : qualifier FSM states.
//   CNT_W_DEFAULT : default width of the saturating glitch/drop counters.
//   sat_inc       : saturating increment, clamps at 2^width-1 (width <= 32).
package cdc_pkg;

  typedef enum logic {CAP_IDLE, CAP_SETTLE} cap_state_e;

  localparam int unsigned CNT_W_DEFAULT = 8;

  function automatic logic [31:0] sat_inc(input logic [31:0] val, input int unsigned width);
    logic [31:0] max_v;
    max_v = (width >= 32) ? '1 : ((32'd1 << width) - 32'd1);
    return (val >= max_v) ? max_v : (val + 32'd1);
  endfunction

endpackage

// File: rtl/cdc_event_fifo.sv
// Single-clock event FIFO holding qualified values.
//   clk, rst_n    : clock, asynchronous active-low reset (clears storage too).
//   push_i/push_data_i : write request and data; ignored when full unless a
//                   pop happens in the same cycle.
//   pop_i         : remove head; ignored when empty.
//   full_o/empty_o/count_o : occupancy status.
//   head_o        : head entry, read from registered storage (no bypass).
module cdc_event_fifo #(
  parameter int unsigned WIDTH      = 8,
  parameter int unsigned FIFO_DEPTH = 4
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          push_i,
  input  logic [WIDTH-1:0]              push_data_i,
  input  logic                          pop_i,
  output logic                          full_o,
  output logic                          empty_o,
  output logic [$clog2(FIFO_DEPTH):0]   count_o,
  output logic [WIDTH-1:0]              head_o
);

  localparam int unsigned AW = $clog2(FIFO_DEPTH);
  localparam int unsigned PW = AW + 1;

  logic [WIDTH-1:0] mem_q [FIFO_DEPTH];
  logic [AW:0]      wr_q, wr_d;
  logic [AW:0]      rd_q, rd_d;
  logic             do_push, do_pop;

  // Pointers carry one extra wrap bit so full and empty are distinguishable.
  assign empty_o = (wr_q == rd_q);
  assign count_o = wr_q - rd_q;
  assign full_o  = (count_o == PW'(FIFO_DEPTH));
  assign do_pop  = pop_i && !empty_o;
  // When full, a same-cycle pop frees the slot being written.
  assign do_push = push_i && (!full_o || do_pop);
  assign head_o  = mem_q[rd_q[AW-1:0]];

  always_comb begin
    wr_d = wr_q;
    rd_d = rd_q;
    if (do_push) wr_d = wr_q + PW'(1);
    if (do_pop)  rd_d = rd_q + PW'(1);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_q <= '0;
      rd_q <= '0;
      for (int unsigned i = 0; i < FIFO_DEPTH; i++) mem_q[i] <= '0;
    end else begin
      wr_q <= wr_d;
      rd_q <= rd_d;
      if (do_push) mem_q[wr_q[AW-1:0]] <= push_data_i;
    end
  end

endmodule

// File: rtl/cdc_stable_capture.sv
// Destination-domain qualifier behind the gray-code synchronizer. A value is
// committed as an event once it has been seen on STABLE_CYCLES consecutive
// valid samples; transients that revert to the last committed value are
// counted as glitches and discarded.
//   clk, reset_n           : clock, asynchronous active-low reset.
//   in_data/in_valid       : synchronizer dst_data/dst_valid.
//   out_data/out_valid/out_ready : event FIFO head and handshake.
//   fifo_count             : occupied FIFO entries.
//   busy                   : a candidate value is settling.
//   overflow               : one-cycle pulse when a commit is dropped (FIFO full).
//   glitch_cnt/drop_cnt    : saturating event counters.
module cdc_stable_capture
  import cdc_pkg::*;
#(
  parameter int unsigned WIDTH         = 8,
  parameter int unsigned STABLE_CYCLES = 2,
  parameter int unsigned FIFO_DEPTH    = 4,
  parameter int unsigned CNT_W         = CNT_W_DEFAULT
) (
  input  logic                        clk,
  input  logic                        reset_n,
  input  logic [WIDTH-1:0]            in_data,
  input  logic                        in_valid,
  output logic [WIDTH-1:0]            out_data,
  output logic                        out_valid,
  input  logic                        out_ready,
  output logic [$clog2(FIFO_DEPTH):0] fifo_count,
  output logic                        busy,
  output logic                        overflow,
  output logic [CNT_W-1:0]            glitch_cnt,
  output logic [CNT_W-1:0]            drop_cnt
);

  if (STABLE_CYCLES < 1) begin : g_bad_stable
    $error("cdc_stable_capture: STABLE_CYCLES must be >= 1");
  end
  if ((FIFO_DEPTH < 2) || ((FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0)) begin : g_bad_depth
    $error("cdc_stable_capture: FIFO_DEPTH must be a power of 2 and >= 2");
  end
  if ((CNT_W < 1) || (CNT_W > 32)) begin : g_bad_cntw
    $error("cdc_stable_capture: CNT_W must be in 1..32");
  end

  localparam int unsigned CW = $clog2(STABLE_CYCLES + 1);

  cap_state_e       state_q, state_d;
  logic [WIDTH-1:0] last_q, last_d;
  logic [WIDTH-1:0] cand_q, cand_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [CNT_W-1:0] glitch_q, glitch_d;
  logic [CNT_W-1:0] drop_q, drop_d;
  logic             ovf_q, ovf_d;

  logic             commit, glitch, drop;
  logic [WIDTH-1:0] commit_val;
  logic             fifo_full, fifo_empty, pop;

  assign pop = !fifo_empty && out_ready;
  // A commit is lost only if the FIFO is full and nothing leaves this cycle.
  assign drop = commit && fifo_full && !pop;

  always_comb begin
    state_d    = state_q;
    last_d     = last_q;
    cand_d     = cand_q;
    cnt_d      = cnt_q;
    commit     = 1'b0;
    commit_val = cand_q;
    glitch     = 1'b0;
    if (in_valid) begin
      unique case (state_q)
        CAP_IDLE: begin
          if (in_data != last_q) begin
            if (STABLE_CYCLES == 1) begin
              commit     = 1'b1;
              commit_val = in_data;
            end else begin
              cand_d  = in_data;
              cnt_d   = CW'(1);
              state_d = CAP_SETTLE;
            end
          end
        end
        CAP_SETTLE: begin
          // The candidate never equals last_q, so these branches are disjoint.
          if (in_data == cand_q) begin
            cnt_d = cnt_q + CW'(1);
            if (cnt_q == CW'(STABLE_CYCLES - 1)) begin
              commit  = 1'b1;
              state_d = CAP_IDLE;
            end
          end else if (in_data == last_q) begin
            glitch  = 1'b1;
            state_d = CAP_IDLE;
          end else begin
            cand_d = in_data;
            cnt_d  = CW'(1);
          end
        end
        default: state_d = CAP_IDLE;
      endcase
    end
    // last_val tracks commits even when dropped, so they are not re-reported.
    if (commit) last_d = commit_val;
  end

  always_comb begin
    glitch_d = glitch ? CNT_W'(sat_inc(32'(glitch_q), CNT_W)) : glitch_q;
    drop_d   = drop   ? CNT_W'(sat_inc(32'(drop_q), CNT_W))   : drop_q;
    ovf_d    = drop;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q  <= CAP_IDLE;
      last_q   <= '0;
      cand_q   <= '0;
      cnt_q    <= '0;
      glitch_q <= '0;
      drop_q   <= '0;
      ovf_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      last_q   <= last_d;
      cand_q   <= cand_d;
      cnt_q    <= cnt_d;
      glitch_q <= glitch_d;
      drop_q   <= drop_d;
      ovf_q    <= ovf_d;
    end
  end

  cdc_event_fifo #(
    .WIDTH      (WIDTH),
    .FIFO_DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk         (clk),
    .rst_n       (reset_n),
    .push_i      (commit),
    .push_data_i (commit_val),
    .pop_i       (pop),
    .full_o      (fifo_full),
    .empty_o     (fifo_empty),
    .count_o     (fifo_count),
    .head_o      (out_data)
  );

  assign out_valid  = !fifo_empty;
  assign busy       = (state_q == CAP_SETTLE);
  assign overflow   = ovf_q;
  assign glitch_cnt = glitch_q;
  assign drop_cnt   = drop_q;

endmodule

// File: tb/tb_cdc_stable_capture.sv
module tb_cdc_stable_capture;

  logic       clk = 1'b0;
  logic       reset_n;
  logic [7:0] in_data;
  logic       in_valid;
  logic [7:0] out_data;
  logic       out_valid;
  logic       out_ready;
  logic [2:0] fifo_count;
  logic       busy;
  logic       overflow;
  logic [7:0] glitch_cnt;
  logic [7:0] drop_cnt;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  cdc_stable_capture #(
    .WIDTH         (8),
    .STABLE_CYCLES (2),
    .FIFO_DEPTH    (4),
    .CNT_W         (8)
  ) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .in_data    (in_data),
    .in_valid   (in_valid),
    .out_data   (out_data),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .fifo_count (fifo_count),
    .busy       (busy),
    .overflow   (overflow),
    .glitch_cnt (glitch_cnt),
    .drop_cnt   (drop_cnt)
  );

  typedef struct {
    logic       v;
    logic [7:0] d;
    logic       r;
    logic       ov;
    logic [7:0] od;
    logic [2:0] cnt;
    logic       bsy;
    logic       ovf;
    logic [7:0] gl;
    logic [7:0] dr;
  } vec_t;

  vec_t tbl[$];

  task automatic add(input logic v, input logic [7:0] d, input logic r,
                     input logic ov, input logic [7:0] od, input logic [2:0] cnt,
                     input logic bsy, input logic ovf, input logic [7:0] gl,
                     input logic [7:0] dr);
    vec_t e;
    e.v = v; e.d = d; e.r = r; e.ov = ov; e.od = od; e.cnt = cnt;
    e.bsy = bsy; e.ovf = ovf; e.gl = gl; e.dr = dr;
    tbl.push_back(e);
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Drive inputs just after an edge, let the next edge take them, then sample.
  task automatic step(input logic v, input logic [7:0] d, input logic r);
    in_valid  = v;
    in_data   = d;
    out_ready = r;
    @(posedge clk);
    #1;
  endtask

  task automatic chk_vec(input string tag, input vec_t e);
    chk({tag, " out_valid"}, 32'(out_valid), 32'(e.ov));
    if (e.ov) chk({tag, " out_data"}, 32'(out_data), 32'(e.od));
    chk({tag, " fifo_count"}, 32'(fifo_count), 32'(e.cnt));
    chk({tag, " busy"}, 32'(busy), 32'(e.bsy));
    chk({tag, " overflow"}, 32'(overflow), 32'(e.ovf));
    chk({tag, " glitch_cnt"}, 32'(glitch_cnt), 32'(e.gl));
    chk({tag, " drop_cnt"}, 32'(drop_cnt), 32'(e.dr));
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, " out_valid"}, 32'(out_valid), 32'd0);
    chk({tag, " out_data"}, 32'(out_data), 32'd0);
    chk({tag, " fifo_count"}, 32'(fifo_count), 32'd0);
    chk({tag, " busy"}, 32'(busy), 32'd0);
    chk({tag, " overflow"}, 32'(overflow), 32'd0);
    chk({tag, " glitch_cnt"}, 32'(glitch_cnt), 32'd0);
    chk({tag, " drop_cnt"}, 32'(drop_cnt), 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    vec_t e;

    // Test 2: 0x00 -> 0x5A, commit after 2nd sample, then pop.
    add(1, 8'h5A, 0, 0, 8'h00, 0, 1, 0, 0, 0);
    add(1, 8'h5A, 0, 1, 8'h5A, 1, 0, 0, 0, 0);
    add(1, 8'h5A, 1, 0, 8'h00, 0, 0, 0, 0, 0);
    // Test 3: glitch, then glitch with invalid gaps.
    add(1, 8'h7F, 0, 0, 8'h00, 0, 1, 0, 0, 0);
    add(1, 8'h5A, 0, 0, 8'h00, 0, 0, 0, 1, 0);
    add(1, 8'h7F, 0, 0, 8'h00, 0, 1, 0, 1, 0);
    add(0, 8'h5A, 0, 0, 8'h00, 0, 1, 0, 1, 0);
    add(0, 8'h7F, 0, 0, 8'h00, 0, 1, 0, 1, 0);
    add(1, 8'h5A, 0, 0, 8'h00, 0, 0, 0, 2, 0);
    // Gaps keep the settle count: 0x33, gap, gap, 0x33 commits.
    add(1, 8'h33, 0, 0, 8'h00, 0, 1, 0, 2, 0);
    add(0, 8'h33, 0, 0, 8'h00, 0, 1, 0, 2, 0);
    add(0, 8'h00, 0, 0, 8'h00, 0, 1, 0, 2, 0);
    add(1, 8'h33, 0, 1, 8'h33, 1, 0, 0, 2, 0);
    add(1, 8'h33, 1, 0, 8'h00, 0, 0, 0, 2, 0);
    // A different value retargets the candidate without a glitch.
    add(1, 8'h44, 0, 0, 8'h00, 0, 1, 0, 2, 0);
    add(1, 8'h55, 0, 0, 8'h00, 0, 1, 0, 2, 0);
    add(1, 8'h55, 0, 1, 8'h55, 1, 0, 0, 2, 0);
    add(1, 8'h55, 1, 0, 8'h00, 0, 0, 0, 2, 0);
    // Test 4: fill with 01..04, 05 dropped.
    add(1, 8'h01, 0, 0, 8'h00, 0, 1, 0, 2, 0);
    add(1, 8'h01, 0, 1, 8'h01, 1, 0, 0, 2, 0);
    add(1, 8'h02, 0, 1, 8'h01, 1, 1, 0, 2, 0);
    add(1, 8'h02, 0, 1, 8'h01, 2, 0, 0, 2, 0);
    add(1, 8'h03, 0, 1, 8'h01, 2, 1, 0, 2, 0);
    add(1, 8'h03, 0, 1, 8'h01, 3, 0, 0, 2, 0);
    add(1, 8'h04, 0, 1, 8'h01, 3, 1, 0, 2, 0);
    add(1, 8'h04, 0, 1, 8'h01, 4, 0, 0, 2, 0);
    add(1, 8'h05, 0, 1, 8'h01, 4, 1, 0, 2, 0);
    add(1, 8'h05, 0, 1, 8'h01, 4, 0, 1, 2, 1);
    // Drain; 0x05 stays on the input and is not re-reported.
    add(1, 8'h05, 1, 1, 8'h02, 3, 0, 0, 2, 1);
    add(1, 8'h05, 1, 1, 8'h03, 2, 0, 0, 2, 1);
    add(1, 8'h05, 1, 1, 8'h04, 1, 0, 0, 2, 1);
    add(1, 8'h05, 1, 0, 8'h00, 0, 0, 0, 2, 1);
    // Test 5: refill, then commit 0x06 while full with a pop.
    add(1, 8'h01, 0, 0, 8'h00, 0, 1, 0, 2, 1);
    add(1, 8'h01, 0, 1, 8'h01, 1, 0, 0, 2, 1);
    add(1, 8'h02, 0, 1, 8'h01, 1, 1, 0, 2, 1);
    add(1, 8'h02, 0, 1, 8'h01, 2, 0, 0, 2, 1);
    add(1, 8'h03, 0, 1, 8'h01, 2, 1, 0, 2, 1);
    add(1, 8'h03, 0, 1, 8'h01, 3, 0, 0, 2, 1);
    add(1, 8'h04, 0, 1, 8'h01, 3, 1, 0, 2, 1);
    add(1, 8'h04, 0, 1, 8'h01, 4, 0, 0, 2, 1);
    add(1, 8'h06, 0, 1, 8'h01, 4, 1, 0, 2, 1);
    add(1, 8'h06, 1, 1, 8'h02, 4, 0, 0, 2, 1);
    add(1, 8'h06, 1, 1, 8'h03, 3, 0, 0, 2, 1);
    add(1, 8'h06, 1, 1, 8'h04, 2, 0, 0, 2, 1);
    add(1, 8'h06, 1, 1, 8'h06, 1, 0, 0, 2, 1);
    add(1, 8'h06, 1, 0, 8'h00, 0, 0, 0, 2, 1);
    // Test 6 setup: two entries queued, 0x0C settling.
    add(1, 8'h0A, 0, 0, 8'h00, 0, 1, 0, 2, 1);
    add(1, 8'h0A, 0, 1, 8'h0A, 1, 0, 0, 2, 1);
    add(1, 8'h0B, 0, 1, 8'h0A, 1, 1, 0, 2, 1);
    add(1, 8'h0B, 0, 1, 8'h0A, 2, 0, 0, 2, 1);
    add(1, 8'h0C, 0, 1, 8'h0A, 2, 1, 0, 2, 1);

    // Reset and test 1.
    reset_n = 1'b0; in_valid = 1'b0; in_data = 8'h00; out_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk_reset_vals("reset");
    reset_n = 1'b1;
    for (int i = 0; i < 20; i++) begin
      step(1, 8'h00, 0);
      chk($sformatf("idle0[%0d] out_valid", i), 32'(out_valid), 32'd0);
      chk($sformatf("idle0[%0d] glitch_cnt", i), 32'(glitch_cnt), 32'd0);
    end

    for (int i = 0; i < tbl.size(); i++) begin
      e = tbl[i];
      step(e.v, e.d, e.r);
      chk_vec($sformatf("vec[%0d]", i), e);
    end

    // Asynchronous reset mid-settle with two entries queued.
    #2;
    reset_n = 1'b0;
    #1;
    chk_reset_vals("async_reset");
    @(negedge clk);
    reset_n = 1'b1;
    @(posedge clk);
    #1;
    // Old last_val 0x0B is new again since last_val returned to 0.
    step(1, 8'h0B, 0);
    chk("post_reset1 busy", 32'(busy), 32'd1);
    chk("post_reset1 out_valid", 32'(out_valid), 32'd0);
    step(1, 8'h0B, 0);
    chk("post_reset2 out_valid", 32'(out_valid), 32'd1);
    chk("post_reset2 out_data", 32'(out_data), 32'h0B);
    chk("post_reset2 fifo_count", 32'(fifo_count), 32'd1);

    // Glitch counter saturates at 255.
    for (int i = 0; i < 260; i++) begin
      step(1, 8'h99, 0);
      step(1, 8'h0B, 0);
    end
    chk("glitch_sat glitch_cnt", 32'(glitch_cnt), 32'd255);
    chk("glitch_sat fifo_count", 32'(fifo_count), 32'd1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
